// File: rtl/aurora_sup_pkg.sv
// Shared definitions for the Aurora link supervisor: FSM state encoding and
// the widths of the timer and the status counters.
package aurora_sup_pkg;

    localparam int TIMER_W  = 24;
    localparam int RETRY_W  = 4;
    localparam int RELINK_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_PULSE     = 3'd0;
    localparam state_t ST_WAIT_SEQ  = 3'd1;
    localparam state_t ST_WAIT_CHAN = 3'd2;
    localparam state_t ST_UP        = 3'd3;
    localparam state_t ST_BACKOFF   = 3'd4;
    localparam state_t ST_FAILED    = 3'd5;

endpackage

// File: rtl/aurora_link_supervisor_soft_err_window.sv
// Soft-error rate detector used by the link supervisor when built with
// SOFT_ERR_RELINK_EN. Counts soft_err pulses inside fixed windows while
// enabled and trips combinationally on the pulse that reaches THRESH.
// Without SOFT_ERR_RELINK_EN this file contributes no logic.
`ifdef SOFT_ERR_RELINK_EN
module soft_err_window #(
    parameter int THRESH = 8,
    parameter int WINDOW = 2**16
)(
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic soft_err,
    output logic trip
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int CNT_W = $clog2(THRESH + 1);

    logic [WIN_W-1:0] win_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             win_end;

    assign win_end = (win_reg == WIN_W'(WINDOW - 1));
    // The threshold pulse itself trips, so the relink starts in the same cycle.
    assign trip    = enable && soft_err && (cnt_reg == CNT_W'(THRESH - 1));

    // Window timer and pulse count; both restart whenever the link leaves UP.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            win_reg <= '0;
            cnt_reg <= '0;
        end else if (win_end) begin
            win_reg <= '0;
            cnt_reg <= soft_err ? CNT_W'(1) : '0;
        end else begin
            win_reg <= win_reg + WIN_W'(1);
            if (soft_err && cnt_reg != CNT_W'(THRESH))
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/aurora_link_supervisor.sv
// Aurora link supervisor: pulses the transceiver reset sequencer, waits for
// the sequence and channel_up, relinks on loss / hard error / request, retries
// with backoff and parks in FAILED after MAX_RETRIES consecutive failures.
// Optional soft-error relink is built when SOFT_ERR_RELINK_EN is defined.
module aurora_link_supervisor
    import aurora_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LINK_TIMEOUT     = 2**23,
    parameter int BACKOFF_CYCLES   = 2**20,
    parameter int MAX_RETRIES      = 7,
    parameter int SOFT_ERR_THRESH  = 8,
    parameter int SOFT_ERR_WINDOW  = 2**16
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                aurora_rst,
    input  logic                channel_up,
    input  logic                hard_err,
    input  logic                soft_err,
    input  logic                force_relink,
    output logic                seq_rst,
    output logic                link_ok,
    output logic                link_fail,
    output logic [RETRY_W-1:0]  retry_cnt,
    output logic [RELINK_W-1:0] relink_cnt
);

    state_t               state_reg, state_next;
    logic [TIMER_W-1:0]   timer_reg;
    logic [RETRY_W-1:0]   retry_reg;
    logic [RELINK_W-1:0]  relink_reg;
    logic                 timeout, pulse_done, backoff_done, soft_trip;
    logic                 seq_rst_next, link_ok_next, link_fail_next;

    assign timeout      = (timer_reg == TIMER_W'(LINK_TIMEOUT - 1));
    assign pulse_done   = (timer_reg == TIMER_W'(RST_PULSE_CYCLES - 1));
    assign backoff_done = (timer_reg == TIMER_W'(BACKOFF_CYCLES - 1));

`ifdef SOFT_ERR_RELINK_EN
    soft_err_window #(
        .THRESH (SOFT_ERR_THRESH),
        .WINDOW (SOFT_ERR_WINDOW)
    ) u_soft_err_window (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (state_reg == ST_UP),
        .soft_err (soft_err),
        .trip     (soft_trip)
    );
`else
    logic unused_soft;
    assign unused_soft = soft_err ^ (SOFT_ERR_THRESH > 0) ^ (SOFT_ERR_WINDOW > 0);
    assign soft_trip   = 1'b0;
`endif

    // State register, attempt timer and status counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= ST_PULSE;
            timer_reg  <= '0;
            retry_reg  <= '0;
            relink_reg <= '0;
        end else begin
            state_reg <= state_next;
            // The link timeout spans both wait states, so that hand-over keeps the timer.
            if (state_next != state_reg &&
                !(state_reg == ST_WAIT_SEQ && state_next == ST_WAIT_CHAN))
                timer_reg <= '0;
            else if (timer_reg != '1)
                timer_reg <= timer_reg + TIMER_W'(1);

            if ((state_reg == ST_WAIT_CHAN && state_next == ST_UP) ||
                (state_reg == ST_FAILED && state_next == ST_PULSE))
                retry_reg <= '0;
            else if ((state_reg == ST_WAIT_SEQ || state_reg == ST_WAIT_CHAN) &&
                     state_next == ST_BACKOFF && retry_reg != RETRY_W'(MAX_RETRIES))
                retry_reg <= retry_reg + RETRY_W'(1);

            if (state_reg == ST_UP && state_next == ST_BACKOFF && relink_reg != '1)
                relink_reg <= relink_reg + RELINK_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_PULSE:
                if (pulse_done) state_next = ST_WAIT_SEQ;
            ST_WAIT_SEQ:
                // Timeout takes priority: entering WAIT_CHAN on the last cycle would
                // carry a timer past the equality compare and never time out.
                if (timeout)          state_next = ST_BACKOFF;
                else if (!aurora_rst) state_next = ST_WAIT_CHAN;
            ST_WAIT_CHAN:
                if (channel_up)       state_next = ST_UP;
                else if (timeout)     state_next = ST_BACKOFF;
            ST_UP:
                if (!channel_up || hard_err || force_relink || soft_trip)
                    state_next = ST_BACKOFF;
            ST_BACKOFF:
                // The retry count is settled on entry, so the exhausted attempt
                // still serves its full backoff before parking in FAILED.
                if (backoff_done)
                    state_next = (retry_reg == RETRY_W'(MAX_RETRIES)) ? ST_FAILED : ST_PULSE;
            ST_FAILED:
                if (force_relink) state_next = ST_PULSE;
            default:
                state_next = ST_PULSE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        seq_rst_next   = (state_reg == ST_PULSE);
        link_ok_next   = (state_reg == ST_UP);
        link_fail_next = (state_reg == ST_FAILED);
    end

    // Registered status outputs, one cycle behind the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seq_rst   <= 1'b1;
            link_ok   <= 1'b0;
            link_fail <= 1'b0;
        end else begin
            seq_rst   <= seq_rst_next;
            link_ok   <= link_ok_next;
            link_fail <= link_fail_next;
        end
    end

    assign retry_cnt  = retry_reg;
    assign relink_cnt = relink_reg;

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Self-checking bench for aurora_link_supervisor with short timing parameters.
// Each vector holds inputs for n cycles, then the outputs are compared with
// the expected record popped from the scoreboard queue.
module tb_aurora_link_supervisor;

    logic       clk = 1'b0;
    logic       reset_n, aurora_rst, channel_up, hard_err, soft_err, force_relink;
    logic       seq_rst, link_ok, link_fail;
    logic [3:0] retry_cnt;
    logic [7:0] relink_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        int         n;
        logic       rst_n, ar, cu, he, se, fr;
        logic       e_seq, e_ok, e_fail;
        logic [3:0] e_retry;
        logic [7:0] e_relink;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];

    aurora_link_supervisor #(
        .RST_PULSE_CYCLES (4),
        .LINK_TIMEOUT     (64),
        .BACKOFF_CYCLES   (8),
        .MAX_RETRIES      (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .aurora_rst   (aurora_rst),
        .channel_up   (channel_up),
        .hard_err     (hard_err),
        .soft_err     (soft_err),
        .force_relink (force_relink),
        .seq_rst      (seq_rst),
        .link_ok      (link_ok),
        .link_fail    (link_fail),
        .retry_cnt    (retry_cnt),
        .relink_cnt   (relink_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input int id, input int n,
                                 input logic rst_n, input logic ar, input logic cu,
                                 input logic he, input logic se, input logic fr,
                                 input logic e_seq, input logic e_ok, input logic e_fail,
                                 input logic [3:0] e_retry, input logic [7:0] e_relink);
        vec_t v;
        v.id = id; v.n = n;
        v.rst_n = rst_n; v.ar = ar; v.cu = cu; v.he = he; v.se = se; v.fr = fr;
        v.e_seq = e_seq; v.e_ok = e_ok; v.e_fail = e_fail;
        v.e_retry = e_retry; v.e_relink = e_relink;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        vec_t e;
        reset_n      = v.rst_n;
        aurora_rst   = v.ar;
        channel_up   = v.cu;
        hard_err     = v.he;
        soft_err     = v.se;
        force_relink = v.fr;
        sb_q.push_back(v);
        repeat (v.n) @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({seq_rst, link_ok, link_fail, retry_cnt, relink_cnt} !==
            {e.e_seq, e.e_ok, e.e_fail, e.e_retry, e.e_relink}) begin
            errors++;
            $display("FAIL vec%0d: got seq_rst=%0b link_ok=%0b link_fail=%0b retry_cnt=%0d relink_cnt=%0d, expected seq_rst=%0b link_ok=%0b link_fail=%0b retry_cnt=%0d relink_cnt=%0d",
                     e.id, seq_rst, link_ok, link_fail, retry_cnt, relink_cnt,
                     e.e_seq, e.e_ok, e.e_fail, e.e_retry, e.e_relink);
        end else begin
            $display("vec%0d ok: seq_rst=%0b link_ok=%0b link_fail=%0b retry_cnt=%0d relink_cnt=%0d",
                     e.id, seq_rst, link_ok, link_fail, retry_cnt, relink_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                  id  n  rst ar cu he se fr  seq ok fl ret rel
        // reset state and first link-up (release is followed by edge 0)
        tbl.push_back(mkv( 0,  3, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mkv( 1,  1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mkv( 2,  3, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mkv( 3,  1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mkv( 4, 15, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mkv( 5, 10, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mkv( 6,  1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mkv( 7,  1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0));
        // one-cycle channel_up drop, backoff of 8, new pulse
        tbl.push_back(mkv( 8,  1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mkv( 9,  1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mkv(10,  7, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mkv(11,  1, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0, 1));
        // channel never comes up: three timed-out attempts, then FAILED
        tbl.push_back(mkv(12,  3, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mkv(13,  1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mkv(14, 62, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mkv(15,  1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mkv(16,  8, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mkv(17,  1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1));
        tbl.push_back(mkv(18, 67, 1, 0, 0, 0, 0, 0,  0, 0, 0, 2, 1));
        tbl.push_back(mkv(19, 76, 1, 0, 0, 0, 0, 0,  0, 0, 0, 3, 1));
        tbl.push_back(mkv(20,  8, 1, 0, 0, 0, 0, 0,  0, 0, 0, 3, 1));
        tbl.push_back(mkv(21,  1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 3, 1));
        tbl.push_back(mkv(22, 20, 1, 0, 0, 0, 0, 0,  0, 0, 1, 3, 1));
        // force_relink out of FAILED
        tbl.push_back(mkv(23,  1, 1, 1, 0, 0, 0, 1,  0, 0, 1, 0, 1));
        tbl.push_back(mkv(24,  1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1));
        // channel_up arrives exactly on the timeout cycle: UP wins
        tbl.push_back(mkv(25, 66, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mkv(26,  1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mkv(27,  1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 1));
        // hard error drop, then force_relink ignored while in BACKOFF
        tbl.push_back(mkv(28,  1, 1, 0, 1, 1, 0, 0,  0, 1, 0, 0, 2));
        tbl.push_back(mkv(29,  1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 2));
        tbl.push_back(mkv(30,  1, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 2));
        tbl.push_back(mkv(31,  1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 2));
        tbl.push_back(mkv(32, 12, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 2));
        // force_relink from UP
        tbl.push_back(mkv(33,  1, 1, 0, 1, 0, 0, 1,  0, 1, 0, 0, 3));
        tbl.push_back(mkv(34,  1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 3));
        tbl.push_back(mkv(35, 15, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 3));

        aurora_rst = 1'b1; channel_up = 1'b0; hard_err = 1'b0;
        soft_err = 1'b0; force_relink = 1'b0; reset_n = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            apply_vec(tbl[i]);

        // Soft-error burst while UP.
`ifdef SOFT_ERR_RELINK_EN
        for (int i = 0; i < 7; i++) begin
            apply_vec(mkv(100 + 2*i, 1, 1, 0, 1, 0, 1, 0,  0, 1, 0, 0, 3));
            apply_vec(mkv(101 + 2*i, 1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 3));
        end
        apply_vec(mkv(120, 1, 1, 0, 1, 0, 1, 0,  0, 1, 0, 0, 4));
        apply_vec(mkv(121, 1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4));
`else
        for (int i = 0; i < 20; i++) begin
            apply_vec(mkv(100 + 2*i, 1, 1, 0, 1, 0, 1, 0,  0, 1, 0, 0, 3));
            apply_vec(mkv(101 + 2*i, 1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 3));
        end
`endif

        // Reset in the middle of operation returns everything to the reset state.
        apply_vec(mkv(200, 1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
